load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the Memory block; owns all data-side traffic to it.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Converts the byte address and funct3 into a word address, byte-lane write mask and lane-replicated write data.
- Extracts and sign/zero-extends load data from the Memory block's one-cycle-latency read port, then returns a one-cycle response pulse.

Parameters:
- MEM_WORDS, 256: number of 32-bit words in the Memory block. Any word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address (rs1+imm)
- req_wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  formatted load data (0 for stores and errors)
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal funct3 or out of range
- mem_addr  out  32  to Memory: word-aligned byte address
- mem_rstrb  out  1  to Memory: read strobe
- mem_wdata  out  32  to Memory: write data
- mem_wmask  out  4  to Memory: byte write enables
- mem_rdata  in  32  from Memory: registered read data

Behaviour:
- Reset (async, resetn=0):
  - State IDLE; all registers cleared.
  - req_ready=1 after release; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_addr=0, mem_rstrb=0, mem_wmask=0, mem_wdata=0.
- States: IDLE, ISSUE, CAPTURE, RESP. req_ready=1 only in IDLE.
- IDLE, on req_valid&&req_ready: latch req_we, req_funct3, req_addr[1:0], word address and wdata.
  - Request erroneous: go to RESP with err=1 and no memory access.
  - Otherwise: go to ISSUE.
- Error conditions:
  - Load funct3 in {011, 110, 111}, or store funct3 >= 011.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - addr[31:2] >= MEM_WORDS.
- ISSUE (exactly one cycle):
  - mem_addr = {addr[31:2], 2'b00}.
  - Load: mem_rstrb=1, mem_wmask=0.
  - Store: mem_rstrb=0, mem_wmask driven as below; Memory writes on the closing edge.
  - Next state: load -> CAPTURE, store -> RESP.
- mem_rstrb and mem_wmask are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last value outside ISSUE.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wmask = 4'b0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wmask = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = rs2, wmask = 4'b1111.
- CAPTURE: mem_rdata is valid in this cycle. Select the lane, then register into rsp_rdata on the closing edge.
  - Byte lane = mem_rdata >> (8*addr[1:0]); half lane = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- RESP: rsp_valid=1 for exactly one cycle with rsp_err and rsp_rdata stable, then IDLE.
  - rsp_rdata = 0 for stores and errors.
  - The core never stalls the response; there is no rsp backpressure.
- Latency, counted from the acceptance edge:
  - Load: rsp_valid in the 3rd following cycle.
  - Store: rsp_valid in the 2nd following cycle.
  - Error: rsp_valid in the 1st following cycle.
- Throughput: one request per 2-4 cycles. Back-to-back requests wait in IDLE; req_valid held while req_ready=0 is ignored.
- Reset mid-operation: resetn falling in any state immediately and asynchronously forces mem_wmask=0 and mem_rstrb=0, so no partial or late write reaches Memory. Any pending response is dropped (no rsp_valid).
- Request fields are sampled only at acceptance; later changes on req_* have no effect.

Test Plan:
(Bench wires the unit to the Memory model preloaded with word100=0x04030201, word101=0x08070605, word103=0xFF0F0E0D.)
1. LB 400, then LW 404 -> rsp_rdata=0x00000001 then 0x08070605. rsp_valid 3 cycles after each accept; mem_rstrb high exactly 1 cycle with mem_addr=400/404; rsp_err=0.
2. LB 415 -> 0xFFFFFFFF; LBU 415 -> 0x000000FF; LH 414 -> 0xFFFFFF0F; LHU 414 -> 0x0000FF0F; LH 412 -> 0x00000E0D.
3. SB 401 rs2=0x123456AA -> ISSUE shows mem_wmask=0010, mem_wdata=0xAAAAAAAA, rsp_valid 2 cycles after accept. Then SH 402 rs2=0xBEEF -> wmask=1100. Then LW 400 -> 0xBEEFAA01.
4. SH 403, LW 402, LW 1024, load funct3=011 -> each gives rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after accept; mem_rstrb and mem_wmask never asserted.
5. SW 404 rs2=0xDEADBEEF, resetn pulled low mid-ISSUE before the clock edge -> mem_wmask drops to 0 immediately. After release: LW 404 returns 0x08070605, no stale rsp_valid, req_ready=1.
6. req_valid held high with two queued loads -> req_ready=0 during ISSUE/CAPTURE/RESP. Second request accepted in the cycle after the first rsp_valid; exactly two responses, in order.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core data request at a time, drives the one-cycle-latency
// Memory block, and returns a formatted response pulse.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        req_err;
  logic        illegal;
  logic        misalign;
  logic        out_of_range;
  logic [31:0] store_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  assign accept = req_valid && (state_q == StIdle);

  // Classify the incoming request and pre-format store data.
  always_comb begin
    illegal      = req_we ? (req_funct3 >= 3'b011)
                          : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misalign     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    req_err      = illegal || misalign || out_of_range;
    unique case (req_funct3[1:0])
      2'b00:   store_data = {4{req_wdata[7:0]}};
      2'b01:   store_data = {2{req_wdata[15:0]}};
      default: store_data = req_wdata;
    endcase
  end

  // Select the addressed lane from Memory read data and extend it.
  always_comb begin
    unique case (off_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'h0, lane_b};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = 32'h0;
    endcase
  end

  // Next-state and strobe decode; strobes only in StIssue so an async reset kills them at once.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_err ? StResp : StIssue;
      end
      StIssue: begin
        if (we_q) begin
          unique case (funct3_q[1:0])
            2'b00:   mem_wmask = 4'b0001 << off_q;
            2'b01:   mem_wmask = off_q[1] ? 4'b1100 : 4'b0011;
            default: mem_wmask = 4'b1111;
          endcase
          state_d = StResp;
        end else begin
          mem_rstrb = 1'b1;
          state_d   = StCapture;
        end
      end
      StCapture: state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Request latch and load-data capture; Memory address/data only move for real accesses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        err_q    <= req_err;
        rdata_q  <= 32'h0;
        if (!req_err) mem_addr_q <= {req_addr[31:2], 2'b00};
        if (!req_err && req_we) mem_wdata_q <= store_data;
      end
      if (state_q == StCapture) rdata_q <= load_data;
    end
  end

  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: Memory block model, transaction-level reference model with a
// per-cycle expectation schedule, directed scenarios and randomized traffic.
module tb_load_store_unit;

  localparam int unsigned MemWords = 256;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MemWords)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rstrb  (mem_rstrb),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata)
  );

  // Memory block driven by the DUT, and the model's own view of memory contents.
  logic [31:0] mem     [MemWords];
  logic [31:0] ref_mem [MemWords];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      100:     return 32'h04030201;
      101:     return 32'h08070605;
      103:     return 32'hFF0F0E0D;
      default: return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
    for (int i = 0; i < 4; i++)
      if (mem_wmask[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Expected DUT outputs for one cycle.
  typedef struct packed {
    logic        ready;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } cyc_t;

  cyc_t cur;
  cyc_t sched[$];

  int n_cmp = 0;
  int n_fail = 0;
  int rsp_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  bit          chk_on = 1'b0;

  function automatic cyc_t idle_c();
    cyc_t c;
    c = '0;
    c.ready = 1'b1;
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Load result straight from memory contents: shift to the addressed byte, cut, extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w;
    w = ref_mem[addr[9:2]] >> (8 * int'(addr[1:0]));
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   return f3[2] ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Schedule the cycles that follow acceptance of one request.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2);
    int   size;
    int   off;
    bit   legal;
    bit   err;
    cyc_t c;
    size  = 1 << f3[1:0];
    off   = int'(addr[1:0]);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((off % size) != 0) || ((addr >> 2) >= 32'(MemWords));
    if (err) begin
      c = '0; c.rvalid = 1'b1; c.err = 1'b1;
      sched.push_back(c);
    end else if (we) begin
      c = '0;
      c.addr = {addr[31:2], 2'b00};
      for (int l = 0; l < 4; l++) begin
        if (l >= off && l < off + size) c.wmask[l] = 1'b1;
        c.wdata[8*l +: 8] = rs2[8*(l % size) +: 8];
      end
      sched.push_back(c);
      c = '0; c.rvalid = 1'b1;
      sched.push_back(c);
    end else begin
      c = '0; c.rstrb = 1'b1; c.addr = {addr[31:2], 2'b00};
      sched.push_back(c);
      c = '0;
      sched.push_back(c);
      c = '0; c.rvalid = 1'b1; c.rdata = ref_load(f3, addr);
      sched.push_back(c);
    end
  endtask

  // Advance the schedule; a store commits to the model memory when its issue cycle closes.
  always @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < 4; i++)
        if (cur.wmask[i]) ref_mem[cur.addr[9:2]][8*i +: 8] = cur.wdata[8*i +: 8];
      if (sched.size() > 0) cur = sched.pop_front();
      else                  cur = idle_c();
    end
  end

  always @(negedge resetn) begin
    sched.delete();
    cur = idle_c();
  end

  // Per-cycle compare against the schedule.
  always @(negedge clk) begin
    if (resetn && chk_on) begin
      chk("req_ready", 32'(req_ready), 32'(cur.ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.rvalid));
      chk("mem_rstrb", 32'(mem_rstrb), 32'(cur.rstrb));
      chk("mem_wmask", 32'(mem_wmask), 32'(cur.wmask));
      if (cur.rvalid) begin
        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
        chk("rsp_rdata", rsp_rdata, cur.rdata);
      end
      if (cur.rstrb || cur.wmask != 4'b0000) chk("mem_addr", mem_addr, cur.addr);
      if (cur.wmask != 4'b0000) chk("mem_wdata", mem_wdata, cur.wdata);
      if (rsp_valid) begin
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        rsp_cnt++;
      end
    end
  end

  // Present a request; while the model says busy, hold req_valid high with junk fields.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (cur.ready) begin
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        model(we, f3, addr, wd);
        done = 1'b1;
      end else begin
        req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_timeout: got busy, want ready within 20 cycles at t=%0t", $time);
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (sched.size() == 0 && cur.ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got busy, want idle within 10 cycles at t=%0t", $time);
    end
  endtask

  task automatic load_chk(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    issue(1'b0, f3, addr, $urandom);
    drain();
    chk(name, last_rdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < int'(MemWords); i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    cur = idle_c();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_rstrb", 32'(mem_rstrb), 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    chk_on = 1'b1;
    #1 chk("rst_req_ready", 32'(req_ready), 32'h1);

    // Pin the model to hand-computed values.
    chk("pin_lb415", ref_load(3'b000, 32'd415), 32'hFFFFFFFF);
    chk("pin_lhu414", ref_load(3'b101, 32'd414), 32'h0000FF0F);
    chk("pin_lh412", ref_load(3'b001, 32'd412), 32'h00000E0D);

    // Basic loads.
    load_chk("lb400", 3'b000, 32'd400, 32'h00000001);
    load_chk("lw404", 3'b010, 32'd404, 32'h08070605);

    // Sign and zero extension.
    load_chk("lb415", 3'b000, 32'd415, 32'hFFFFFFFF);
    load_chk("lbu415", 3'b100, 32'd415, 32'h000000FF);
    load_chk("lh414", 3'b001, 32'd414, 32'hFFFFFF0F);
    load_chk("lhu414", 3'b101, 32'd414, 32'h0000FF0F);
    load_chk("lh412", 3'b001, 32'd412, 32'h00000E0D);

    // Stores then readback.
    issue(1'b1, 3'b000, 32'd401, 32'h123456AA);
    drain();
    issue(1'b1, 3'b001, 32'd402, 32'h0000BEEF);
    drain();
    load_chk("lw400_after_st", 3'b010, 32'd400, 32'hBEEFAA01);

    // Error cases.
    issue(1'b1, 3'b001, 32'd403, 32'h11223344);
    drain();
    chk("err_sh403", 32'(last_err), 32'h1);
    issue(1'b0, 3'b010, 32'd402, 32'h0);
    drain();
    chk("err_lw402", 32'(last_err), 32'h1);
    issue(1'b0, 3'b010, 32'd1024, 32'h0);
    drain();
    chk("err_lw1024", 32'(last_err), 32'h1);
    issue(1'b0, 3'b011, 32'd400, 32'h0);
    drain();
    chk("err_f3_011", 32'(last_err), 32'h1);
    chk("err_rdata", last_rdata, 32'h0);

    // Reset while a store is in its issue cycle.
    c0 = rsp_cnt;
    issue(1'b1, 3'b010, 32'd404, 32'hDEADBEEF);
    chk("sw_issue_wmask", 32'(mem_wmask), 32'hF);
    #1 resetn = 1'b0;
    #1;
    chk("rst_mid_wmask", 32'(mem_wmask), 32'h0);
    chk("rst_mid_rstrb", 32'(mem_rstrb), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 chk("rst_mid_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    chk("rst_mid_no_rsp", 32'(rsp_cnt - c0), 32'h0);
    load_chk("lw404_after_rst", 3'b010, 32'd404, 32'h08070605);

    // Back-to-back requests with req_valid held.
    c0 = rsp_cnt;
    issue(1'b0, 3'b010, 32'd400, 32'h0);
    issue(1'b0, 3'b000, 32'd413, 32'h0);
    drain();
    chk("b2b_count", 32'(rsp_cnt - c0), 32'h2);
    chk("b2b_last", last_rdata, 32'h0000000E);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (we ? 3'($urandom_range(0, 2))
                                                           : 3'($urandom_range(0, 5)));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(1016, 1031));
        default: addr = 32'($urandom_range(400, 415));
      endcase
      issue(we, f3, addr, $urandom);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
